// File: rtl/mergelist_loader_pkg.sv
// Shared constants for the mergesort word memory and its serial loader.
package mergelist_loader_pkg;

  localparam int ML_WORD_W = 8;
  localparam int ML_DEPTH  = 32;
  localparam int ML_ADDR_W = 5;

  // Same encodings as the sort stages so state can be probed uniformly.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/mergelist_loader_if.sv
// Word-memory write port: req held until ack, address/data stable while req high.
interface mergelist_loader_if
  import mergelist_loader_pkg::*;
#(
  parameter int WORD_W = ML_WORD_W,
  parameter int ADDR_W = ML_ADDR_W
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ack);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ack);
endinterface

// File: rtl/mergelist_loader_shifter.sv
// Serial-to-parallel shifter with bit counter; MSB arrives first.
// Latency: word/word_complete are combinational on the WORD_W-th sampled bit.
// Backpressure: none; the parent decides whether a completed word is kept.
module mergelist_loader_shifter #(
  parameter int WORD_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word,
  output logic              word_complete
);
  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[WORD_W-2:0], bit_in};
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Expose the word including the bit being sampled so the parent can capture it at this edge.
  assign word          = {shreg[WORD_W-2:0], bit_in};
  assign word_complete = shift_en && (bit_cnt == LAST_BIT);

endmodule

// File: rtl/mergelist_loader.sv
// Loads DEPTH serial MSB-first words into addresses 0..DEPTH-1 of the sort memory.
// Latency: mem_we rises the cycle after a word's last bit; load_done 2 cycles after last bit with ack tied high.
// Backpressure: one-word hold register; a word completing while a write is still unacked is dropped (overrun).
module mergelist_loader
  import mergelist_loader_pkg::*;
#(
  parameter int WORD_W = ML_WORD_W,
  parameter int DEPTH  = ML_DEPTH,
  parameter int ADDR_W = ML_ADDR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               serial_valid,
  input  logic               serial_in,
  mergelist_loader_if.master mem,
  output logic               busy,
  output logic               load_done,
  output logic               overrun
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  word_cnt;
  logic              accept_start;
  logic              list_full;
  logic              shift_en;
  logic              hold_free;
  logic              write_xfer;
  logic              last_xfer;
  logic [WORD_W-1:0] word;
  logic              word_complete;

  assign accept_start = start && (state != ST_SHIFT);
  // word_cnt counts captured words, so it is also the address of the next word.
  assign list_full    = (word_cnt == FULL_CNT);
  assign shift_en     = (state == ST_SHIFT) && serial_valid && !list_full;
  assign write_xfer   = mem.mem_we && mem.mem_ack;
  assign hold_free    = !mem.mem_we || mem.mem_ack;
  assign last_xfer    = write_xfer && (mem.mem_addr == LAST_ADDR);

  mergelist_loader_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clock         (clock),
    .reset         (reset),
    .clear         (accept_start),
    .shift_en      (shift_en),
    .bit_in        (serial_in),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      word_cnt      <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      overrun       <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else if (accept_start) begin
      state     <= ST_SHIFT;
      word_cnt  <= '0;
      busy      <= 1'b1;
      load_done <= 1'b0;
      overrun   <= 1'b0;
    end else if (state == ST_SHIFT) begin
      if (word_complete) begin
        if (hold_free) begin
          mem.mem_we    <= 1'b1;
          mem.mem_addr  <= word_cnt[ADDR_W-1:0];
          mem.mem_wdata <= word;
          word_cnt      <= word_cnt + CNT_W'(1);
        end else begin
          overrun <= 1'b1;
        end
      end else if (write_xfer) begin
        mem.mem_we <= 1'b0;
      end
      if (last_xfer) begin
        state     <= ST_DONE;
        busy      <= 1'b0;
        load_done <= 1'b1;
      end
    end
  end

endmodule
